// File: rtl/xgriscv_halt_monitor.sv
// xgriscv_halt_monitor: end-of-test detector (tohost/end-pc/timeout) with console byte FIFO
module xgriscv_halt_monitor #(
  parameter int                   ADDR_SIZE    = 32,
  parameter logic [ADDR_SIZE-1:0] TOHOST_ADDR  = 32'h8000_1000,
  parameter logic [ADDR_SIZE-1:0] CONSOLE_ADDR = 32'h8000_1004,
  parameter logic [ADDR_SIZE-1:0] END_PC       = 32'h8000_0078,
  parameter int                   TIMEOUT      = 100000,
  parameter int                   FIFO_DEPTH   = 4
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic [ADDR_SIZE-1:0] pc,
  input  logic                 mem_we,
  input  logic [ADDR_SIZE-1:0] mem_addr,
  input  logic [ADDR_SIZE-1:0] mem_wdata,
  output logic                 done,
  output logic                 pass,
  output logic [30:0]          fail_code,
  output logic [ADDR_SIZE-1:0] cycles,
  output logic                 con_valid,
  output logic [7:0]           con_data,
  input  logic                 con_ready,
  output logic                 con_overflow
);
  localparam int PW = $clog2(FIFO_DEPTH);
  typedef enum logic {RUN, HALT} state_t;
  state_t               state_q, state_d;
  logic [ADDR_SIZE-1:0] cycles_q, cycles_d, cyc_inc;
  logic                 pass_q, pass_d, ovf_q, ovf_d;
  logic [30:0]          fail_q, fail_d;
  logic [7:0]           mem_q [FIFO_DEPTH];
  logic [PW-1:0]        rd_q, wr_q;
  logic [PW:0]          cnt_q;
  logic                 run, th, push, pop, full, wr_en;
  always_comb begin
    run = state_q == RUN;
    cyc_inc = cycles_q + ADDR_SIZE'(1);
    th = run && mem_we && mem_addr == TOHOST_ADDR && mem_wdata[0];
    state_d = state_q;
    cycles_d = cycles_q;
    pass_d = pass_q;
    fail_d = fail_q;
    if (run) begin
      cycles_d = cyc_inc;
      if (th) begin
        state_d = HALT;
        pass_d = mem_wdata[31:1] == '0;
        fail_d = mem_wdata[31:1];
      end else if (pc == END_PC) begin
        state_d = HALT;
        pass_d = 1'b1;
        fail_d = '0;
      end else if (TIMEOUT != 0 && cyc_inc == ADDR_SIZE'(TIMEOUT)) begin
        state_d = HALT;
        pass_d = 1'b0;
        fail_d = '1;
      end
    end
    push = run && mem_we && mem_addr == CONSOLE_ADDR;
    pop = cnt_q != '0 && con_ready;
    full = cnt_q == (PW+1)'(FIFO_DEPTH);
    // a full FIFO still accepts a push when the head leaves on the same edge
    wr_en = push && (!full || pop);
    ovf_d = ovf_q | (push && full && !pop);
  end
  always_ff @(posedge clk) begin
    if (rstn) begin
      state_q <= RUN;
      cycles_q <= '0;
      pass_q <= 1'b0;
      fail_q <= '0;
      ovf_q <= 1'b0;
      rd_q <= '0;
      wr_q <= '0;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      cycles_q <= cycles_d;
      pass_q <= pass_d;
      fail_q <= fail_d;
      ovf_q <= ovf_d;
      rd_q <= rd_q + PW'(pop);
      wr_q <= wr_q + PW'(wr_en);
      cnt_q <= cnt_q + (PW+1)'(wr_en) - (PW+1)'(pop);
    end
  end
  always_ff @(posedge clk) begin
    if (!rstn && wr_en) mem_q[wr_q] <= mem_wdata[7:0];
  end
  assign done = state_q == HALT;
  assign pass = pass_q;
  assign fail_code = fail_q;
  assign cycles = cycles_q;
  assign con_valid = cnt_q != '0;
  assign con_data = con_valid ? mem_q[rd_q] : 8'h0;
  assign con_overflow = ovf_q;
endmodule

// File: tb/tb_xgriscv_halt_monitor.sv
// tb_xgriscv_halt_monitor: directed vector table plus a timeout sequence on a second instance
module tb_xgriscv_halt_monitor;
  localparam logic [31:0] T = 32'h8000_1000;
  localparam logic [31:0] C = 32'h8000_1004;
  localparam logic [31:0] E = 32'h8000_0078;
  localparam logic [31:0] I = 32'h8000_0000;
  logic clk = 1'b0;
  logic rstn, mem_we, con_ready;
  logic [31:0] pc, mem_addr, mem_wdata;
  logic done, pass, con_valid, con_overflow;
  logic [30:0] fail_code;
  logic [31:0] cycles;
  logic [7:0] con_data;
  logic t_done, t_pass, t_valid, t_ovf;
  logic [30:0] t_fail;
  logic [31:0] t_cyc;
  logic [7:0] t_data;
  int n_cmp = 0;
  int n_bad = 0;
  always #5 clk = ~clk;
  xgriscv_halt_monitor u_dut (
    .clk(clk), .rstn(rstn), .pc(pc), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .done(done), .pass(pass), .fail_code(fail_code),
    .cycles(cycles), .con_valid(con_valid), .con_data(con_data),
    .con_ready(con_ready), .con_overflow(con_overflow)
  );
  xgriscv_halt_monitor #(.TIMEOUT(20)) u_to (
    .clk(clk), .rstn(rstn), .pc(I), .mem_we(1'b0), .mem_addr(32'h0),
    .mem_wdata(32'h0), .done(t_done), .pass(t_pass), .fail_code(t_fail),
    .cycles(t_cyc), .con_valid(t_valid), .con_data(t_data),
    .con_ready(1'b0), .con_overflow(t_ovf)
  );
  typedef struct {
    logic        rst;
    logic [31:0] pc;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wd;
    logic        rdy;
    logic        done;
    logic        pass;
    logic [30:0] fc;
    logic [31:0] cyc;
    logic        val;
    logic [7:0]  dat;
    logic        ovf;
  } vec_t;
  vec_t vq[$];
  task automatic v(input logic rst, input logic [31:0] p, input logic we, input logic [31:0] a,
                   input logic [31:0] wd, input logic rdy, input logic d, input logic ps,
                   input logic [30:0] fc, input logic [31:0] cy, input logic vl,
                   input logic [7:0] dt, input logic ov);
    vq.push_back('{rst, p, we, a, wd, rdy, d, ps, fc, cy, vl, dt, ov});
  endtask
  task automatic chk(input string nm, input int i, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s row %0d: got %h expected %h", nm, i, act, exp);
    end
  endtask
  task automatic drive(input logic r, input logic [31:0] p, input logic we, input logic [31:0] a,
                       input logic [31:0] wd, input logic rdy);
    rstn = r; pc = p; mem_we = we; mem_addr = a; mem_wdata = wd; con_ready = rdy;
  endtask
  initial begin
    drive(1, I, 0, 0, 0, 0);
    @(posedge clk); #1;
    chk("to_reset_done", 0, 32'(t_done), 0);
    chk("to_reset_cyc", 0, t_cyc, 0);
    rstn = 0;
    repeat (19) @(posedge clk);
    #1;
    chk("to_pre_done", 19, 32'(t_done), 0);
    chk("to_pre_cyc", 19, t_cyc, 19);
    @(posedge clk); #1;
    chk("to_done", 20, 32'(t_done), 1);
    chk("to_pass", 20, 32'(t_pass), 0);
    chk("to_fail", 20, 32'(t_fail), 32'h7FFF_FFFF);
    chk("to_cyc", 20, t_cyc, 20);
    @(posedge clk); #1;
    chk("to_frozen_cyc", 21, t_cyc, 20);
    chk("to_frozen_done", 21, 32'(t_done), 1);
    // end pc on the 10th edge after reset, then halt ignores stores
    v(1, I, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int k = 1; k <= 9; k++) v(0, I, 0, 0, 0, 0, 0, 0, 0, k, 0, 0, 0);
    v(0, E, 0, 0, 0, 0, 1, 1, 0, 10, 0, 0, 0);
    v(0, I, 1, T, 7, 0, 1, 1, 0, 10, 0, 0, 0);
    v(0, I, 1, C, "Z", 0, 1, 1, 0, 10, 0, 0, 0);
    // tohost: store during reset, no strobe, byte offset and bit0=0 all ignored
    v(1, I, 1, T, 3, 0, 0, 0, 0, 0, 0, 0, 0);
    v(0, I, 0, T, 1, 0, 0, 0, 0, 1, 0, 0, 0);
    v(0, I, 1, T + 1, 1, 0, 0, 0, 0, 2, 0, 0, 0);
    v(0, I, 1, T, 6, 0, 0, 0, 0, 3, 0, 0, 0);
    v(0, I, 1, T, 7, 0, 1, 0, 3, 4, 0, 0, 0);
    v(0, I, 0, 0, 0, 0, 1, 0, 3, 4, 0, 0, 0);
    // tohost beats end pc
    v(1, I, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    v(0, E, 1, T, 1, 0, 1, 1, 0, 1, 0, 0, 0);
    v(1, I, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    v(0, E, 1, T, 5, 0, 1, 0, 2, 1, 0, 0, 0);
    v(1, I, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    v(0, I, 1, T, 32'hFFFF_FFFF, 0, 1, 0, 31'h7FFF_FFFF, 1, 0, 0, 0);
    // console overflow then drain
    v(1, I, 1, C, "A", 0, 0, 0, 0, 0, 0, 0, 0);
    v(0, I, 1, C, "A", 0, 0, 0, 0, 1, 1, "A", 0);
    v(0, I, 1, C, "B", 0, 0, 0, 0, 2, 1, "A", 0);
    v(0, I, 1, C, "C", 0, 0, 0, 0, 3, 1, "A", 0);
    v(0, I, 1, C, "D", 0, 0, 0, 0, 4, 1, "A", 0);
    v(0, I, 1, C, "E", 0, 0, 0, 0, 5, 1, "A", 1);
    v(0, I, 0, 0, 0, 1, 0, 0, 0, 6, 1, "B", 1);
    v(0, I, 0, 0, 0, 1, 0, 0, 0, 7, 1, "C", 1);
    v(0, I, 0, 0, 0, 1, 0, 0, 0, 8, 1, "D", 1);
    v(0, I, 0, 0, 0, 1, 0, 0, 0, 9, 0, 0, 1);
    // full FIFO push+pop, ordered drain, reset mid-drain
    v(1, I, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    v(0, I, 1, C, "a", 0, 0, 0, 0, 1, 1, "a", 0);
    v(0, I, 1, C, "b", 0, 0, 0, 0, 2, 1, "a", 0);
    v(0, I, 1, C, "c", 0, 0, 0, 0, 3, 1, "a", 0);
    v(0, I, 1, C, "d", 0, 0, 0, 0, 4, 1, "a", 0);
    v(0, I, 1, C, "X", 1, 0, 0, 0, 5, 1, "b", 0);
    v(0, I, 0, 0, 0, 1, 0, 0, 0, 6, 1, "c", 0);
    v(0, I, 0, 0, 0, 1, 0, 0, 0, 7, 1, "d", 0);
    v(0, I, 0, 0, 0, 1, 0, 0, 0, 8, 1, "X", 0);
    v(1, I, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
    // push+pop on empty, then drain continues in HALT while pushes are ignored
    v(0, I, 1, C, "Q", 1, 0, 0, 0, 1, 1, "Q", 0);
    v(0, I, 0, 0, 0, 1, 0, 0, 0, 2, 0, 0, 0);
    v(0, I, 1, C, "H", 0, 0, 0, 0, 3, 1, "H", 0);
    v(0, E, 0, 0, 0, 0, 1, 1, 0, 4, 1, "H", 0);
    v(0, E, 1, C, "J", 1, 1, 1, 0, 4, 0, 0, 0);
    foreach (vq[i]) begin
      drive(vq[i].rst, vq[i].pc, vq[i].we, vq[i].addr, vq[i].wd, vq[i].rdy);
      @(posedge clk); #1;
      chk("done", i, 32'(done), 32'(vq[i].done));
      chk("pass", i, 32'(pass), 32'(vq[i].pass));
      chk("fail_code", i, 32'(fail_code), 32'(vq[i].fc));
      chk("cycles", i, cycles, vq[i].cyc);
      chk("con_valid", i, 32'(con_valid), 32'(vq[i].val));
      chk("con_data", i, 32'(con_data), 32'(vq[i].dat));
      chk("con_overflow", i, 32'(con_overflow), 32'(vq[i].ovf));
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
